// File: rtl/nv_nvdla_pdp_rdma_req_pipe.sv
// Elastic valid/ready pipe stage for the PDP RDMA ingress request path.
// Output register plus DEPTH-1 entry skid FIFO; ready, valid, data and occupancy all come from flops.
module nv_nvdla_pdp_rdma_req_pipe #(
  parameter  int WIDTH = 79,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             pipe_flush,
  input  logic             req_valid_d0,
  output logic             req_ready_d0,
  input  logic [WIDTH-1:0] req_pd_d0,
  output logic             req_valid_d1,
  input  logic             req_ready_d1,
  output logic [WIDTH-1:0] req_pd_d1,
  output logic [CNT_W-1:0] occupancy
);

  localparam int SKID_N = DEPTH - 1;
  localparam int PTR_W  = (SKID_N > 1) ? $clog2(SKID_N) : 1;
  localparam int MEM_N  = 2 ** PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_p1;
  logic             vld_p1;
  logic             rdy_p0;
  logic [WIDTH-1:0] pd_p1;
  logic [WIDTH-1:0] skid_mem [MEM_N];
  logic [PTR_W-1:0] wptr_p0;
  logic [PTR_W-1:0] rptr_p0;

  logic             push;
  logic             pop;
  logic             out_free;
  logic             skid_empty;
  logic             load_skid;
  logic             load_in;
  logic             skid_wr;
  logic             vld_nxt;
  logic [CNT_W-1:0] skid_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push       = req_valid_d0 & rdy_p0;
    pop        = vld_p1 & req_ready_d1;
    skid_cnt   = cnt_p1 - CNT_W'(vld_p1);
    skid_empty = (skid_cnt == '0);
    out_free   = ~vld_p1 | pop;
    // Skid head has priority over the input so FIFO order is kept.
    load_skid  = out_free & ~skid_empty;
    load_in    = out_free & skid_empty & push;
    skid_wr    = push & ~load_in;
    vld_nxt    = out_free ? (~skid_empty | push) : 1'b1;
    cnt_nxt    = cnt_p1 + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state: count, output valid, upstream ready, skid pointers
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
      rdy_p0  <= 1'b1;
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else if (pipe_flush) begin
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
      rdy_p0  <= 1'b1;
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else begin
      cnt_p1 <= cnt_nxt;
      vld_p1 <= vld_nxt;
      rdy_p0 <= (cnt_nxt < CNT_FULL);
      if (skid_wr) begin
        wptr_p0 <= ptr_inc(wptr_p0);
      end
      if (load_skid) begin
        rptr_p0 <= ptr_inc(rptr_p0);
      end
    end
  end

  // Data state: output register and skid storage, not reset
  always_ff @(posedge nvdla_core_clk) begin
    if (load_skid) begin
      pd_p1 <= skid_mem[rptr_p0];
    end else if (load_in) begin
      pd_p1 <= req_pd_d0;
    end
    if (skid_wr) begin
      skid_mem[wptr_p0] <= req_pd_d0;
    end
  end

  assign req_ready_d0 = rdy_p0;
  assign req_valid_d1 = vld_p1;
  assign req_pd_d1    = pd_p1;
  assign occupancy    = cnt_p1;

endmodule
